// File: rtl/screen_fill_pkg.sv
// Shared types for the screen-fill DMA: FSM states and fill pattern selection.
package screen_fill_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_t;

    typedef enum logic {
        PAT_SOLID,
        PAT_ALT
    } pattern_t;

endpackage

// File: rtl/screen_fill_pattern.sv
// Purpose: produce the fill word for one screen index (solid or value/~value alternation).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller holds the index while the CPU owns the port.
module screen_fill_pattern
    import screen_fill_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  idx_lsb,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  sel,
    output logic [DATA_WIDTH-1:0] word
);

    pattern_t pat;

    assign pat  = sel ? PAT_ALT : PAT_SOLID;
    assign word = (pat == PAT_ALT && idx_lsb) ? ~value : value;

endmodule

// File: rtl/screen_fill_dma.sv
// Purpose: fill the RAM screen region with a latched word, stealing RAM cycles the CPU leaves idle
//   (alternating value/~value pattern available when SCREEN_FILL_PATTERN_EN is defined).
// Latency: first write one cycle after start; CPU path is combinational. Backpressure: cpu_req stalls the fill.
module screen_fill_dma
    import screen_fill_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 12,
    parameter int SCREEN_OFFSET = 0,
    parameter int SCREEN_WORDS  = 24
) (
    input  logic                  cpu_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] fill_value,
    input  logic                  pattern_sel,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = $clog2(SCREEN_WORDS + 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(SCREEN_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(SCREEN_OFFSET);

    generate
        if ((longint'(SCREEN_OFFSET) + longint'(SCREEN_WORDS)) > (longint'(1) << ADDR_WIDTH)) begin : g_range_err
            $error("screen_fill_dma: screen region exceeds RAM address space");
        end
    endgenerate

    state_t                state;
    logic [IDX_W-1:0]      index;
    logic [DATA_WIDTH-1:0] value_q;
    logic [DATA_WIDTH-1:0] fill_word;
    logic                  dma_wr;

`ifdef SCREEN_FILL_PATTERN_EN
    pattern_t pat_q;

    screen_fill_pattern #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pattern (
        .idx_lsb(index[0]),
        .value  (value_q),
        .sel    (pat_q == PAT_ALT),
        .word   (fill_word)
    );
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign fill_word          = value_q;
`endif

    // A fill slot exists only when the CPU is off the port; abort and reset forfeit it.
    assign dma_wr = (state == FILL) && !cpu_req && !abort && !reset;

    always_comb begin
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (dma_wr) begin
            ram_we    = 1'b1;
            ram_addr  = BASE + ADDR_WIDTH'(index);
            ram_wdata = fill_word;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state   <= IDLE;
            index   <= '0;
            value_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SCREEN_FILL_PATTERN_EN
            pat_q   <= PAT_SOLID;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FILL;
                        index   <= '0;
                        value_q <= fill_value;
                        busy    <= 1'b1;
`ifdef SCREEN_FILL_PATTERN_EN
                        pat_q   <= pattern_sel ? PAT_ALT : PAT_SOLID;
`endif
                    end
                end
                FILL: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (!cpu_req) begin
                        if (index == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            index <= index + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
